sparse_pe: RTL and testbench



---
 rtl/sparse_pe_pkg.sv | 37 +++
 rtl/sparse_pe_mac.sv | 56 +++++
 rtl/sparse_pe.sv | 153 +++++++++++++++
 tb/tb_sparse_pe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pe_pkg.sv
// Shared types, constants and the requantisation helper for the sparse PE.
// The optional SPARSE_PE_RELU_EN macro is consumed by sparse_pe.sv.
package sparse_pe_pkg;

  localparam int DEF_IA_CH     = 8;
  localparam int DEF_K_OUT     = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_OUT_SHIFT = 4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_PROC  = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Fixed-width record so the typedef works for any DATA_W <= 16 / K_W < 16.
  typedef struct packed {
    logic               valid;
    logic signed [31:0] product;
    logic [15:0]        k;
  } s1_t;

  function automatic longint sat_shift(input longint acc, input int shift, input int dw);
    longint v;
    longint hi;
    longint lo;
    v  = acc >>> shift;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/sparse_pe_mac.sv
// Two-stage multiply/accumulate pipeline feeding a bank of K_OUT accumulators.
// Out-of-range output-channel beats flow through S1 and are dropped at S2.
module sparse_pe_mac
  import sparse_pe_pkg::*;
#(
  parameter  int K_OUT  = DEF_K_OUT,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ACC_W  = DEF_ACC_W,
  localparam int K_W    = $clog2(K_OUT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_w_data,
  input  logic                     i_tbl_valid,
  input  logic signed [DATA_W-1:0] i_tbl_data,
  input  logic [K_W:0]             i_k,
  output logic [K_OUT*ACC_W-1:0]   o_acc
);

  s1_t                       r_s1;
  logic signed [ACC_W-1:0]   r_acc [K_OUT];
  logic signed [2*DATA_W-1:0] w_mul;
  logic signed [2*DATA_W-1:0] w_prod;

  assign w_mul  = i_w_data * i_tbl_data;
  assign w_prod = i_tbl_valid ? w_mul : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= '0;
    end else begin
      r_s1.valid <= i_valid;
      if (i_valid) begin
        r_s1.product <= 32'(w_prod);
        r_s1.k       <= 16'(i_k);
      end
    end
  end

  // Single-cycle read-modify-write, so consecutive beats to one k need no bypass.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      for (int k = 0; k < K_OUT; k++) r_acc[k] <= '0;
    end else if (r_s1.valid && (r_s1.k < 16'(K_OUT))) begin
      r_acc[r_s1.k[K_W-1:0]] <= r_acc[r_s1.k[K_W-1:0]] + ACC_W'(r_s1.product);
    end
  end

  always_comb begin
    o_acc = '0;
    for (int k = 0; k < K_OUT; k++) o_acc[k*ACC_W +: ACC_W] = r_acc[k];
  end

endmodule

// File: rtl/sparse_pe.sv
// Sparse MAC processing element: FSM, dense IA table, weight handshake, OA register.
// Define SPARSE_PE_RELU_EN to clamp output activations at zero.
module sparse_pe
  import sparse_pe_pkg::*;
#(
  parameter  int IA_CH     = DEF_IA_CH,
  parameter  int K_OUT     = DEF_K_OUT,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ACC_W     = DEF_ACC_W,
  parameter  int OUT_SHIFT = DEF_OUT_SHIFT,
  localparam int C_W       = $clog2(IA_CH),
  localparam int K_W       = $clog2(K_OUT),
  localparam int LEN_W     = $clog2(IA_CH) + 1,
  localparam int WLEN_W    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_acc_clr,
  input  logic [IA_CH*DATA_W-1:0] i_ia_data,
  input  logic [IA_CH*C_W-1:0]    i_ia_c_idx,
  input  logic [LEN_W-1:0]        i_ia_len,
  input  logic [WLEN_W-1:0]       i_w_len,
  input  logic                    i_w_valid,
  output logic                    o_w_ready,
  input  logic [DATA_W-1:0]       i_w_data,
  input  logic [C_W-1:0]          i_w_c_idx,
  input  logic [K_W:0]            i_w_k_idx,
  output logic                    o_finish,
  output logic [K_OUT*DATA_W-1:0] o_oa
);

  state_t                  r_state;
  logic                    r_acc_clr;
  logic [WLEN_W-1:0]       r_w_len;
  logic [WLEN_W-1:0]       r_beat_cnt;
  logic [IA_CH*DATA_W-1:0] r_ia_data;
  logic [IA_CH*C_W-1:0]    r_ia_c_idx;
  logic [LEN_W-1:0]        r_ia_len;
  logic [IA_CH-1:0]        r_tbl_valid;
  logic [DATA_W-1:0]       r_tbl_data [IA_CH];
  logic                    r_flush_cnt;
  logic                    r_finish;
  logic [K_OUT*DATA_W-1:0] r_oa;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_clr;
  logic [K_OUT*ACC_W-1:0]  w_acc;
  logic [K_OUT*DATA_W-1:0] w_oa;
  longint                  w_q;

  // Weight handshake: a beat transfers on any edge where i_w_valid && o_w_ready.
  assign w_ready   = (r_state == ST_PROC) && (r_beat_cnt < r_w_len);
  assign w_accept  = i_w_valid && w_ready;
  assign w_clr     = (r_state == ST_LOAD) && r_acc_clr;
  assign o_w_ready = w_ready;
  assign o_finish  = r_finish;
  assign o_oa      = r_oa;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_acc_clr   <= 1'b0;
      r_w_len     <= '0;
      r_beat_cnt  <= '0;
      r_ia_data   <= '0;
      r_ia_c_idx  <= '0;
      r_ia_len    <= '0;
      r_flush_cnt <= 1'b0;
      r_finish    <= 1'b0;
      r_oa        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_acc_clr  <= i_acc_clr;
          r_w_len    <= i_w_len;
          r_ia_data  <= i_ia_data;
          r_ia_c_idx <= i_ia_c_idx;
          r_ia_len   <= i_ia_len;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r_beat_cnt  <= '0;
          r_flush_cnt <= 1'b0;
          r_state     <= (r_w_len != '0) ? ST_PROC : ST_FLUSH;
        end
        ST_PROC: begin
          if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (r_beat_cnt == r_w_len) r_state <= ST_FLUSH;
        end
        ST_FLUSH: if (r_flush_cnt) begin
          r_oa     <= w_oa;
          r_finish <= 1'b1;
          r_state  <= ST_DONE;
        end else begin
          r_flush_cnt <= 1'b1;
        end
        ST_DONE: if (!i_start) begin
          r_finish <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Later entries overwrite earlier ones on duplicate c_idx; lengths above IA_CH clamp naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tbl_valid <= '0;
    end else if (r_state == ST_LOAD) begin
      r_tbl_valid <= '0;
      for (int j = 0; j < IA_CH; j++) begin
        if (j < int'(r_ia_len)) begin
          r_tbl_valid[r_ia_c_idx[j*C_W +: C_W]] <= 1'b1;
          r_tbl_data[r_ia_c_idx[j*C_W +: C_W]]  <= r_ia_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  sparse_pe_mac #(
    .K_OUT  (K_OUT),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_valid     (w_accept),
    .i_w_data    (i_w_data),
    .i_tbl_valid (r_tbl_valid[i_w_c_idx]),
    .i_tbl_data  (r_tbl_data[i_w_c_idx]),
    .i_k         (i_w_k_idx),
    .o_acc       (w_acc)
  );

  always_comb begin
    w_oa = '0;
    w_q  = 0;
    for (int k = 0; k < K_OUT; k++) begin
      w_q = sat_shift(longint'($signed(w_acc[k*ACC_W +: ACC_W])), OUT_SHIFT, DATA_W);
`ifdef SPARSE_PE_RELU_EN
      if (w_q < 0) w_q = 0;
`else
      w_q = w_q;
`endif
      w_oa[k*DATA_W +: DATA_W] = w_q[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_sparse_pe.sv
// Directed bench for sparse_pe: a reference accumulator model feeds an expected-OA queue
// that is drained and compared when o_finish rises.
module tb_sparse_pe;

  localparam int IA_CH     = 8;
  localparam int K_OUT     = 16;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 24;
  localparam int OUT_SHIFT = 0;

  logic                    clk = 1'b0;
  logic                    i_rst, i_start, i_acc_clr, i_w_valid;
  logic [IA_CH*DATA_W-1:0] i_ia_data;
  logic [IA_CH*3-1:0]      i_ia_c_idx;
  logic [3:0]              i_ia_len;
  logic [15:0]             i_w_len;
  logic                    o_w_ready, o_finish;
  logic [DATA_W-1:0]       i_w_data;
  logic [2:0]              i_w_c_idx;
  logic [4:0]              i_w_k_idx;
  logic [K_OUT*DATA_W-1:0] o_oa;

  int          checks = 0;
  int          errors = 0;
  int          ia_d [IA_CH];
  int          ia_c [IA_CH];
  int          ia_len;
  int          bw [32];
  int          bc [32];
  int          bk [32];
  longint      m_acc [K_OUT];
  bit          m_tv [IA_CH];
  longint      m_td [IA_CH];
  logic [DATA_W-1:0] exp_q [$];
  time         last_t;

  sparse_pe #(
    .IA_CH(IA_CH), .K_OUT(K_OUT), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_acc_clr(i_acc_clr),
    .i_ia_data(i_ia_data), .i_ia_c_idx(i_ia_c_idx), .i_ia_len(i_ia_len),
    .i_w_len(i_w_len), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
    .i_w_data(i_w_data), .i_w_c_idx(i_w_c_idx), .i_w_k_idx(i_w_k_idx),
    .o_finish(o_finish), .o_oa(o_oa)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint wrap_acc(input longint a);
    longint v;
    v = a & ((longint'(1) <<< ACC_W) - 1);
    if (v >= (longint'(1) <<< (ACC_W - 1))) v = v - (longint'(1) <<< ACC_W);
    return v;
  endfunction

  function automatic longint oa_of(input longint acc);
    longint v;
    v = acc >>> OUT_SHIFT;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef SPARSE_PE_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic do_reset(input int n);
    i_rst = 1'b1; i_start = 1'b0; i_w_valid = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_finish", longint'(o_finish), 0);
    chk("rst_ready", longint'(o_w_ready), 0);
    chk("rst_oa_zero", longint'(o_oa == '0), 1);
    for (int k = 0; k < K_OUT; k++) m_acc[k] = 0;
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_pass(input bit clr, input int nb);
    int lim;
    for (int j = 0; j < IA_CH; j++) begin
      i_ia_data[j*8 +: 8]  = 8'(ia_d[j]);
      i_ia_c_idx[j*3 +: 3] = 3'(ia_c[j]);
    end
    i_ia_len  = 4'(ia_len);
    i_w_len   = 16'(nb);
    i_acc_clr = clr;
    i_start   = 1'b1;
    for (int c = 0; c < IA_CH; c++) m_tv[c] = 1'b0;
    lim = (ia_len > IA_CH) ? IA_CH : ia_len;
    for (int j = 0; j < lim; j++) begin
      m_tv[ia_c[j]] = 1'b1;
      m_td[ia_c[j]] = longint'(ia_d[j]);
    end
    if (clr) for (int k = 0; k < K_OUT; k++) m_acc[k] = 0;
    @(posedge clk);
    last_t = $time;
    @(negedge clk);
  endtask

  task automatic send_beats(input int first, input int n, input bit gaps);
    int     budget;
    longint prod;
    for (int i = first; i < first + n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_w_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      i_w_valid = 1'b1;
      i_w_data  = 8'(bw[i]);
      i_w_c_idx = 3'(bc[i]);
      i_w_k_idx = 5'(bk[i]);
      budget = 0;
      while (!o_w_ready && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      if (!o_w_ready) begin
        chk("beat_ready_timeout", longint'(o_w_ready), 1);
        break;
      end
      @(posedge clk);
      last_t = $time;
      prod = m_tv[bc[i]] ? longint'(bw[i]) * m_td[bc[i]] : 0;
      if (bk[i] < K_OUT) m_acc[bk[i]] = wrap_acc(m_acc[bk[i]] + prod);
      @(negedge clk);
    end
    i_w_valid = 1'b0;
  endtask

  task automatic finish_pass(input string tag);
    int          n;
    bit          saw_ready;
    logic [7:0]  e;
    logic [7:0]  lane1;
    for (int k = 0; k < K_OUT; k++) exp_q.push_back(8'(oa_of(m_acc[k])));
    lane1 = 8'(oa_of(m_acc[1]));
    chk({tag, "_ready_low"}, longint'(o_w_ready), 0);
    n = 0;
    saw_ready = 1'b0;
    while (!o_finish && n < 500) begin
      @(negedge clk);
      if (o_w_ready) saw_ready = 1'b1;
      n++;
    end
    chk({tag, "_finish"}, longint'(o_finish), 1);
    chk({tag, "_latency"}, longint'($time - last_t), 35);
    chk({tag, "_no_ready"}, longint'(saw_ready), 0);
    for (int k = 0; k < K_OUT; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_oa%0d", tag, k), longint'($signed(o_oa[k*8 +: 8])), longint'($signed(e)));
    end
    repeat (2) @(negedge clk);
    chk({tag, "_finish_hold"}, longint'(o_finish), 1);
    chk({tag, "_oa1_hold"}, longint'($signed(o_oa[8 +: 8])), longint'($signed(lane1)));
    i_start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, longint'(o_finish), 0);
  endtask

  task automatic clear_ia();
    for (int j = 0; j < IA_CH; j++) begin
      ia_d[j] = 0;
      ia_c[j] = 0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_acc_clr = 1'b0; i_w_valid = 1'b0;
    i_ia_data = '0; i_ia_c_idx = '0; i_ia_len = '0; i_w_len = '0;
    i_w_data = '0; i_w_c_idx = '0; i_w_k_idx = '0;
    do_reset(2);

    // Pass A: IA {c0:2, c3:-3}; lane 1 = 6 - 12 = -6, lane 0 = 0 (c2 absent).
    clear_ia();
    ia_d[0] = 2; ia_c[0] = 0; ia_d[1] = -3; ia_c[1] = 3; ia_len = 2;
    bw[0] = 3; bc[0] = 0; bk[0] = 1;
    bw[1] = 4; bc[1] = 3; bk[1] = 1;
    bw[2] = 5; bc[2] = 2; bk[2] = 0;
    start_pass(1'b1, 3);
    send_beats(0, 3, 1'b0);
    finish_pass("passA");

    // Pass B continues accumulation: lane 1 = -6 + 7 = 1.
    clear_ia();
    ia_d[0] = 1; ia_c[0] = 0; ia_len = 1;
    bw[0] = 7; bc[0] = 0; bk[0] = 1;
    start_pass(1'b0, 1);
    send_beats(0, 1, 1'b0);
    finish_pass("passB");

    // Reset after 3 of 5 beats, then rerun without clearing: reset must have zeroed accumulators.
    clear_ia();
    ia_d[0] = 5; ia_c[0] = 1; ia_d[1] = -2; ia_c[1] = 4; ia_d[2] = 3; ia_c[2] = 6; ia_len = 3;
    for (int i = 0; i < 5; i++) begin
      bw[i] = 2 * i - 3; bc[i] = (i % 2 == 0) ? 1 : 4; bk[i] = i + 2;
    end
    start_pass(1'b1, 5);
    send_beats(0, 3, 1'b0);
    do_reset(2);
    start_pass(1'b0, 5);
    send_beats(0, 5, 1'b1);
    finish_pass("rst_rerun");

    // Saturation in both directions.
    clear_ia();
    ia_d[0] = 127; ia_c[0] = 0; ia_len = 1;
    for (int i = 0; i < 20; i++) begin
      bw[i] = 127; bc[i] = 0; bk[i] = 0;
    end
    start_pass(1'b1, 20);
    send_beats(0, 20, 1'b0);
    finish_pass("sat_pos");
    for (int i = 0; i < 20; i++) bw[i] = -127;
    start_pass(1'b1, 20);
    send_beats(0, 20, 1'b0);
    finish_pass("sat_neg");

    // Empty pass: no weight beats, no IA entries.
    clear_ia();
    ia_len = 0;
    start_pass(1'b1, 0);
    finish_pass("empty");

    // Random pass: clamped ia_len, duplicate c_idx, an out-of-range k beat, valid gaps.
    for (int j = 0; j < IA_CH; j++) begin
      ia_d[j] = int'($urandom_range(0, 6)) - 3;
      ia_c[j] = int'($urandom_range(0, 7));
    end
    ia_c[6] = ia_c[2];
    ia_len = 12;
    for (int i = 0; i < 12; i++) begin
      bw[i] = int'($urandom_range(0, 6)) - 3;
      bc[i] = int'($urandom_range(0, 7));
      bk[i] = int'($urandom_range(0, K_OUT - 1));
    end
    bw[4] = 100; bc[4] = ia_c[6]; bk[4] = K_OUT;
    start_pass(1'b1, 12);
    send_beats(0, 12, 1'b1);
    finish_pass("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
